noc_rx_mailbox: RTL and testbench

//  Receive-side buffer between the inter-core network link and the Nios "recv_data" input PIO.
//  - Accepts 32-bit words from the link under a valid/ready handshake.
//  - Stores them in a small FIFO.
//  - Presents the head word, registered, on out_data for the PIO to read.
//  - Software releases the head word by toggling a bit on an output PIO (pop_toggle).
//  - Status (valid, fill level, sticky errors) is exported on a second 32-bit word for a status PIO.

---
 rtl/noc_rx_mailbox.sv | 98 +++++++++
 tb/tb_noc_rx_mailbox.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_rx_mailbox.sv
// Receive mailbox between the network link and the Nios recv_data PIO.
// Small FIFO with a registered head word, toggle-driven pop and a status word.
module noc_rx_mailbox #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              pop_toggle,
    input  logic              clr_sticky,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [31:0]       status
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              pop_toggle_q;
    logic              underflow_err;
    logic [7:0]        drop_cnt;
    logic              push;
    logic              pop_req;
    logic              pop;
    logic              bypass;
    logic [DATA_W-1:0] head_next;

    // Handshake: a word transfers on any posedge where rx_valid & rx_ready are both 1;
    // rx_ready depends only on the count register, so the sender may hold rx_valid freely.
    assign rx_ready = (count != FULL);
    assign push     = rx_valid & rx_ready;
    assign pop_req  = pop_toggle ^ pop_toggle_q;
    assign pop      = pop_req & (count != '0);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    // The new head is the word being written this cycle whenever nothing older survives the pop.
    assign bypass      = push & (count == {{ADDR_W{1'b0}}, pop});
    assign head_next   = bypass ? rx_data : mem[rd_ptr_next];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pop_toggle_q  <= 1'b0;
            underflow_err <= 1'b0;
            drop_cnt      <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
        end else begin
            pop_toggle_q <= pop_toggle;
            count        <= count_next;
            rd_ptr       <= rd_ptr_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (clr_sticky) begin
                underflow_err <= 1'b0;
            end else if (pop_req && count == '0) begin
                underflow_err <= 1'b1;
            end
            if (clr_sticky) begin
                drop_cnt <= '0;
            end else if (rx_valid && !rx_ready && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            out_valid <= (count_next != '0);
            out_data  <= (count_next != '0) ? head_next : '0;
        end
    end

    assign status = {underflow_err, 7'b0, drop_cnt, 11'b0, out_valid, 4'(count)};

endmodule

// File: tb/tb_noc_rx_mailbox.sv
// Bench for noc_rx_mailbox: directed vector table, hand sequences for reset and
// sticky errors, and random traffic checked against a queue-based reference.
module tb_noc_rx_mailbox;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              pop_toggle = 1'b0;
    logic              clr_sticky = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [31:0]       status;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] exp_q[$];
    logic              m_uf;
    int                m_drop;
    logic              m_toggle_q;

    noc_rx_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .pop_toggle (pop_toggle),
        .clr_sticky (clr_sticky),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .status     (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(exp_q.size());
        if (exp_q.size() != 0) s = s + 32'h10;
        s = s + (32'(m_drop) << 16);
        if (m_uf) s = s + 32'h8000_0000;
        return s;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_uf       = 1'b0;
        m_drop     = 0;
        m_toggle_q = 1'b0;
    endtask

    // Applies the sampled inputs of one clock edge to the reference model.
    task automatic model_edge();
        bit ready;
        ready = (exp_q.size() != DEPTH);
        if (pop_toggle != m_toggle_q) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            else m_uf = 1'b1;
        end
        if (rx_valid && ready) exp_q.push_back(rx_data);
        if (rx_valid && !ready && m_drop < 255) m_drop++;
        if (clr_sticky) begin
            m_uf   = 1'b0;
            m_drop = 0;
        end
        m_toggle_q = pop_toggle;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        chk({tag, " out_data"}, out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        chk({tag, " status"}, status, model_status());
    endtask

    // One cycle: drive at negedge, check rx_ready before the edge, outputs after it.
    task automatic step(input logic [31:0] d, input logic v, input logic p, input logic c);
        @(negedge clk);
        rx_data    = d;
        rx_valid   = v;
        clr_sticky = c;
        if (p) pop_toggle = ~pop_toggle;
        #1;
        chk("rx_ready", 32'(rx_ready), 32'(exp_q.size() != DEPTH));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("step");
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset rx_ready", 32'(rx_ready), 32'h1);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset status", status, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        pop;
        logic        clr;
        logic        exp_ov;
        logic [31:0] exp_od;
        int          exp_cnt;
        int          exp_drop;
    } vec_t;

    vec_t vec[22];

    initial begin
        vec[0]  = '{32'hDEADBEEF, 1, 0, 0, 1, 32'hDEADBEEF, 1, 0};
        vec[1]  = '{32'h0,        0, 1, 0, 0, 32'h0,        0, 0};
        vec[2]  = '{32'hA1,       1, 0, 0, 1, 32'hA1,       1, 0};
        vec[3]  = '{32'hA2,       1, 0, 0, 1, 32'hA1,       2, 0};
        vec[4]  = '{32'hA3,       1, 0, 0, 1, 32'hA1,       3, 0};
        vec[5]  = '{32'hA4,       1, 0, 0, 1, 32'hA1,       4, 0};
        vec[6]  = '{32'hA5,       1, 0, 0, 1, 32'hA1,       4, 1};
        vec[7]  = '{32'hA5,       1, 0, 0, 1, 32'hA1,       4, 2};
        vec[8]  = '{32'hA5,       1, 0, 0, 1, 32'hA1,       4, 3};
        vec[9]  = '{32'h0,        0, 1, 0, 1, 32'hA2,       3, 3};
        vec[10] = '{32'hA5,       1, 0, 0, 1, 32'hA2,       4, 3};
        vec[11] = '{32'h0,        0, 1, 0, 1, 32'hA3,       3, 3};
        vec[12] = '{32'h0,        0, 1, 0, 1, 32'hA4,       2, 3};
        vec[13] = '{32'h0,        0, 1, 0, 1, 32'hA5,       1, 3};
        vec[14] = '{32'h0,        0, 1, 0, 0, 32'h0,        0, 3};
        vec[15] = '{32'hB1,       1, 0, 0, 1, 32'hB1,       1, 3};
        vec[16] = '{32'hB2,       1, 0, 0, 1, 32'hB1,       2, 3};
        vec[17] = '{32'hB3,       1, 1, 0, 1, 32'hB2,       2, 3};
        vec[18] = '{32'h0,        0, 1, 0, 1, 32'hB3,       1, 3};
        vec[19] = '{32'hC1,       1, 1, 0, 1, 32'hC1,       1, 3};
        vec[20] = '{32'h0,        0, 1, 0, 0, 32'h0,        0, 3};
        vec[21] = '{32'h0,        0, 0, 1, 0, 32'h0,        0, 0};

        assert_reset();

        for (int i = 0; i < 22; i++) begin
            step(vec[i].data, vec[i].valid, vec[i].pop, vec[i].clr);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vec[i].exp_ov));
            chk($sformatf("vec%0d out_data", i), out_data, vec[i].exp_od);
            chk($sformatf("vec%0d count", i), 32'(status[3:0]), 32'(vec[i].exp_cnt));
            chk($sformatf("vec%0d drop_cnt", i), 32'(status[23:16]), 32'(vec[i].exp_drop));
        end

        // Underflow, clear, and clear winning over a simultaneous underflow
        step(32'h0, 0, 1, 0);
        chk("underflow set", 32'(status[31]), 32'h1);
        step(32'h0, 0, 0, 1);
        chk("underflow cleared", 32'(status[31]), 32'h0);
        step(32'h0, 0, 1, 1);
        chk("clr beats underflow", 32'(status[31]), 32'h0);
        step(32'h0, 0, 0, 0);

        // Ten words with alternating pops; pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            step(32'h5000_0000 + 32'(i), 1, 0, 0);
            chk($sformatf("wrap head %0d", i), out_data, 32'h5000_0000 + 32'(i));
            step(32'h0, 0, 1, 0);
        end

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 29) == 0));
        end

        // Reset mid-traffic with three words held, pop_toggle high at release
        assert_reset();
        for (int i = 0; i < 3; i++) step(32'h7000_0000 + 32'(i), 1, 0, 0);
        chk("pre-reset count", 32'(status[3:0]), 32'h3);
        @(negedge clk);
        rx_valid   = 1'b1;
        pop_toggle = 1'b1;
        #2;
        assert_reset();
        step(32'h0, 0, 0, 0);
        chk("release underflow", 32'(status[31]), 32'h1);
        chk("release out_valid", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
